fpm_arbiter: RTL and testbench
==============================

// Module: fpm_arbiter
// PURPOSE
//  Shares one FPMUL multiplier core among NREQ requesters (e.g. CPU wrapper
//  port, DMA/vector engine). Round-robin grant; latches the winner's operands,
//  issues a one-cycle Start pulse, waits for Done, and returns the product and
//  flags to the granted requester only. Sits between requester ports and FPMUL.
// PARAMETERS
//  NREQ     2   number of requesters (2..4)
//  TIMEOUT  64  cycles in WAIT before abort (used only with FPM_TIMEOUT_EN)
// PORTS
//  clk        in   1        system clock, rising edge
//  rst        in   1        asynchronous, active-low reset
//  req        in   NREQ     level request per requester; hold until ack
//  req_a      in   32*NREQ  operand A, requester i at [32*i+31:32*i]
//  req_b      in   32*NREQ  operand B, same packing
//  ack        out  NREQ     one-hot, 1-cycle: operands captured, may drop req
//  rsp_valid  out  NREQ     one-hot, 1-cycle: result valid for requester i
//  rsp_p      out  32       product, held until next RESP
//  rsp_flags  out  6        {of,uf,nanf,inff,dnf,zf}, held with rsp_p
//  rsp_err    out  1        timeout abort flag, valid with rsp_valid
//  busy       out  1        high in any state except IDLE
//  mul_a      out  32       to FPMUL A (registered)
//  mul_b      out  32       to FPMUL B (registered)
//  mul_start  out  1        to FPMUL Start, 1-cycle pulse
//  mul_done   in   1        from FPMUL Done
//  mul_p      in   32       from FPMUL P
//  mul_flags  in   6        from FPMUL {OF,UF,NaNF,InfF,DNF,ZF}
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE; ack, rsp_valid, mul_start, busy, rsp_err
//   = 0; rsp_p, rsp_flags, mul_a, mul_b = 0; last-grant pointer = NREQ-1
//   (requester 0 has highest priority after reset). Reset mid-transaction
//   drops it silently; no rsp_valid is produced for it.
//  FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
//  IDLE : if |req, winner = first set req[] searching from last+1 modulo
//   NREQ; register g=winner, mul_a/mul_b <= winner's operands; go ISSUE.
//   No req: stay.
//  ISSUE: exactly 1 cycle; mul_start=1, ack[g]=1; go WAIT.
//  WAIT : on mul_done=1, capture rsp_p<=mul_p, rsp_flags<=mul_flags,
//   rsp_err<=0; go RESP. Otherwise stay.
//  RESP : rsp_valid[g]=1 for 1 cycle; last<=g; go IDLE.
//  Latency: req sampled in IDLE cycle T -> ack/mul_start at T+1; Done at
//   cycle D -> rsp_valid at D+1. Min turnaround IDLE->IDLE = 4 + core latency.
//  req still high in the IDLE cycle after RESP is a new request, arbitrated
//   normally (round-robin prevents starvation: max wait = NREQ-1 grants).
//  mul_done outside WAIT is ignored. mul_a/mul_b stay stable from ISSUE
//   until the next IDLE grant. req changes outside IDLE are ignored.
//  Multiple req rising in the same IDLE cycle: single winner per rotation.
// CONFIGURATION
//  FPM_TIMEOUT_EN defined: WAIT cycle counter (clog2(TIMEOUT+1) bits) cleared
//   on entering WAIT; reaching TIMEOUT without mul_done -> rsp_p=0,
//   rsp_flags=0, rsp_err=1, go RESP. mul_done and timeout in the same cycle:
//   mul_done wins (rsp_err=0).
//  FPM_TIMEOUT_EN undefined: no counter, rsp_err tied 0, WAIT waits forever.
// TESTING
//  1 Reset, req=2'b01, A=0x40000000, B=0x40400000 -> ack[0] 1 cycle after,
//    one mul_start pulse, rsp_valid[0] with rsp_p=0x40C00000, flags=0.
//  2 req=2'b11 held continuously -> grants alternate 0,1,0,1; each ack and
//    rsp_valid one-hot; never two grants back-to-back to the same requester.
//  3 Grant requester 1, assert rst=0 during WAIT -> all outputs 0 at once,
//    no rsp_valid; after release req=2'b11 -> requester 0 granted first.
//  4 A=0x7F800000, B=0x00000000 -> rsp_valid with nanf set in rsp_flags;
//    A=0x7F7FFFFF, B=0x40000000 -> of set.
//  5 FPM_TIMEOUT_EN, TIMEOUT=64, mul_done held 0 -> rsp_valid exactly 64
//    cycles after entering WAIT, rsp_err=1, rsp_p=0; next request works.
//  6 Pulse mul_done in IDLE and ISSUE -> no rsp_valid, FSM unaffected.

Source files
------------

// File: rtl/fpm_arbiter.sv
// fpm_arbiter: round-robin sharing of one FPMUL core among NREQ ports.
// Optional WAIT watchdog enabled by defining FPM_TIMEOUT_EN.
module fpm_arbiter #(
   parameter int NREQ    = 2,
   parameter int TIMEOUT = 64
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NREQ-1:0]     req,
   input  logic [32*NREQ-1:0]  req_a,
   input  logic [32*NREQ-1:0]  req_b,
   output logic [NREQ-1:0]     ack,
   output logic [NREQ-1:0]     rsp_valid,
   output logic [31:0]         rsp_p,
   output logic [5:0]          rsp_flags,
   output logic                rsp_err,
   output logic                busy,
   output logic [31:0]         mul_a,
   output logic [31:0]         mul_b,
   output logic                mul_start,
   input  logic                mul_done,
   input  logic [31:0]         mul_p,
   input  logic [5:0]          mul_flags
);

   localparam int IW = $clog2(NREQ);

   if (NREQ < 2 || NREQ > 4) begin : g_bad_nreq
      $error("fpm_arbiter: NREQ must be 2..4");
   end
   if (TIMEOUT < 1) begin : g_bad_timeout
      $error("fpm_arbiter: TIMEOUT must be >= 1");
   end

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_RESP
   } state_e;

   state_e          state_q, state_d;
   logic [IW-1:0]   g_q, g_d;
   logic [IW-1:0]   last_q, last_d;
   logic [31:0]     a_q, a_d;
   logic [31:0]     b_q, b_d;
   logic [31:0]     p_q, p_d;
   logic [5:0]      f_q, f_d;

   logic [IW-1:0]   win;
   logic            win_vld;
   logic [IW:0]     rot;
   logic [31:0]     win_a;
   logic [31:0]     win_b;
   logic            timeout;

   // Round-robin search: scan from last+1 upward; nearest set req wins.
   always_comb begin
      win     = last_q;
      win_vld = 1'b0;
      rot     = '0;
      for (int k = NREQ; k >= 1; k--) begin
         rot = {1'b0, last_q} + (IW+1)'(k);
         if (rot >= (IW+1)'(NREQ)) begin
            rot = rot - (IW+1)'(NREQ);
         end
         if (req[rot[IW-1:0]]) begin
            win     = rot[IW-1:0];
            win_vld = 1'b1;
         end
      end
   end

   // Select the winning requester's operand pair.
   always_comb begin
      win_a = '0;
      win_b = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (win == IW'(i)) begin
            win_a = req_a[32*i +: 32];
            win_b = req_b[32*i +: 32];
         end
      end
   end

`ifdef FPM_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          err_q, err_d;

   // WAIT cycle counter; held at zero outside WAIT so it restarts on entry.
   always_comb begin
      cnt_d = '0;
      if (state_q == S_WAIT) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   // Watchdog fires on the last permitted WAIT cycle.
   assign timeout = (state_q == S_WAIT) &&
                    (cnt_q == CW'(TIMEOUT - 1));

   // Error flag: Done wins over a simultaneous timeout.
   always_comb begin
      err_d = err_q;
      if (state_q == S_WAIT) begin
         if (mul_done) begin
            err_d = 1'b0;
         end else if (timeout) begin
            err_d = 1'b1;
         end
      end
   end

   // Watchdog registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

   assign rsp_err = err_q;
`else
   assign timeout = 1'b0;
   assign rsp_err = 1'b0;
`endif

   // FSM state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (win_vld) begin
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (mul_done || timeout) begin
               state_d = S_RESP;
            end
         end
         S_RESP: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // FSM outputs: one-hot strobes toward the granted requester.
   always_comb begin
      ack       = '0;
      rsp_valid = '0;
      mul_start = 1'b0;
      busy      = (state_q != S_IDLE);
      if (state_q == S_ISSUE) begin
         ack[g_q]  = 1'b1;
         mul_start = 1'b1;
      end
      if (state_q == S_RESP) begin
         rsp_valid[g_q] = 1'b1;
      end
   end

   // Datapath next values: grant/operand latch, result capture, pointer.
   always_comb begin
      g_d    = g_q;
      last_d = last_q;
      a_d    = a_q;
      b_d    = b_q;
      p_d    = p_q;
      f_d    = f_q;
      unique case (state_q)
         S_IDLE: begin
            if (win_vld) begin
               g_d = win;
               a_d = win_a;
               b_d = win_b;
            end
         end
         S_WAIT: begin
            if (mul_done) begin
               p_d = mul_p;
               f_d = mul_flags;
            end else if (timeout) begin
               p_d = '0;
               f_d = '0;
            end
         end
         S_RESP: begin
            last_d = g_q;
         end
         default: begin
         end
      endcase
   end

   // Datapath registers; pointer resets so requester 0 wins first.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         g_q    <= '0;
         last_q <= IW'(NREQ - 1);
         a_q    <= '0;
         b_q    <= '0;
         p_q    <= '0;
         f_q    <= '0;
      end else begin
         g_q    <= g_d;
         last_q <= last_d;
         a_q    <= a_d;
         b_q    <= b_d;
         p_q    <= p_d;
         f_q    <= f_d;
      end
   end

   assign mul_a     = a_q;
   assign mul_b     = b_q;
   assign rsp_p     = p_q;
   assign rsp_flags = f_q;

endmodule

// File: tb/tb_fpm_arbiter.sv
// tb_fpm_arbiter: scoreboard bench for fpm_arbiter with a mock FPMUL.
// Define FPM_TIMEOUT_EN to include the watchdog scenario.
module tb_fpm_arbiter;

   localparam int NREQ = 2;
   localparam int TO   = 64;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  req;
   logic [63:0] req_a, req_b;
   logic [1:0]  ack, rsp_valid;
   logic [31:0] rsp_p;
   logic [5:0]  rsp_flags;
   logic        rsp_err, busy;
   logic [31:0] mul_a, mul_b;
   logic        mul_start, mul_done;
   logic [31:0] mul_p;
   logic [5:0]  mul_flags;

   logic [31:0] opa [2];
   logic [31:0] opb [2];
   int          want  [2];
   int          acked [2];

   logic        core_done, stray_done, hang;
   int          lat, cd;
   logic [31:0] core_p;
   logic [5:0]  core_f;
   logic        prev_done;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      int          idx;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] p;
      logic [5:0]  f;
      logic        err;
   } exp_t;

   exp_t ackq [$];
   exp_t rspq [$];

   assign req_a     = {opa[1], opa[0]};
   assign req_b     = {opb[1], opb[0]};
   assign mul_done  = core_done | stray_done;
   assign mul_p     = core_p;
   assign mul_flags = core_f;

   fpm_arbiter #(.NREQ(NREQ), .TIMEOUT(TO)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .req_a     (req_a),
      .req_b     (req_b),
      .ack       (ack),
      .rsp_valid (rsp_valid),
      .rsp_p     (rsp_p),
      .rsp_flags (rsp_flags),
      .rsp_err   (rsp_err),
      .busy      (busy),
      .mul_a     (mul_a),
      .mul_b     (mul_b),
      .mul_start (mul_start),
      .mul_done  (mul_done),
      .mul_p     (mul_p),
      .mul_flags (mul_flags)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Mock FPMUL products, hand-computed for the directed vectors.
   function automatic logic [37:0] core_model(input logic [31:0] a,
                                              input logic [31:0] b);
      logic [63:0] k;
      k = {a, b};
      case (k)
         64'h40000000_40400000: return {32'h40C00000, 6'h00};
         64'h3F800000_3F800000: return {32'h3F800000, 6'h00};
         64'h40400000_40400000: return {32'h41100000, 6'h00};
         64'h40800000_3F000000: return {32'h40000000, 6'h00};
         64'h7F800000_00000000: return {32'h7FC00000, 6'h08};
         64'h7F7FFFFF_40000000: return {32'h7F800000, 6'h24};
         default:               return {32'hDEADBEEF, 6'h3F};
      endcase
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         cd        <= 0;
         core_done <= 1'b0;
         core_p    <= '0;
         core_f    <= '0;
      end else begin
         core_done <= 1'b0;
         if (mul_start && !hang) begin
            cd               <= lat;
            {core_p, core_f} <= core_model(mul_a, mul_b);
         end else if (cd != 0) begin
            cd <= cd - 1;
            if (cd == 1) core_done <= 1'b1;
         end
      end
   end

   // Requester driver: hold req while unacked requests remain.
   initial begin
      req = '0;
      forever begin
         @(posedge clk);
         #1;
         for (int i = 0; i < NREQ; i++) begin
            if (ack[i]) acked[i]++;
            req[i] = (want[i] > acked[i]);
         end
      end
   end

   // Monitor: pop expectations whenever the DUT strobes ack or rsp_valid.
   initial begin
      exp_t e;
      prev_done = 1'b0;
      forever begin
         @(negedge clk);
         if (ack != '0) begin
            if (ackq.size() == 0) begin
               chk("ack_unexpected", 64'(ack), 64'd0);
            end else begin
               e = ackq.pop_front();
               chk("ack_onehot", 64'(ack), 64'd1 << e.idx);
               chk("ack_start", 64'(mul_start), 64'd1);
               chk("ack_mul_a", 64'(mul_a), 64'(e.a));
               chk("ack_mul_b", 64'(mul_b), 64'(e.b));
            end
         end
         if (rsp_valid != '0) begin
            if (rspq.size() == 0) begin
               chk("rsp_unexpected", 64'(rsp_valid), 64'd0);
            end else begin
               e = rspq.pop_front();
               chk("rsp_onehot", 64'(rsp_valid), 64'd1 << e.idx);
               chk("rsp_p", 64'(rsp_p), 64'(e.p));
               chk("rsp_flags", 64'(rsp_flags), 64'(e.f));
               chk("rsp_err", 64'(rsp_err), 64'(e.err));
               if (!e.err) chk("rsp_after_done", 64'(prev_done), 64'd1);
            end
         end
         prev_done = mul_done;
      end
   end

   task automatic go(input int idx, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] p,
                     input logic [5:0] f, input logic err);
      exp_t e;
      e = '{idx: idx, a: a, b: b, p: p, f: f, err: err};
      opa[idx] = a;
      opb[idx] = b;
      ackq.push_back(e);
      rspq.push_back(e);
   endtask

   task automatic drain(input string nm);
      int c;
      c = 0;
      while ((ackq.size() != 0 || rspq.size() != 0 || busy ||
              want[0] > acked[0] || want[1] > acked[1]) && c < 400) begin
         @(negedge clk);
         c++;
      end
      chk(nm, 64'(c < 400), 64'd1);
   endtask

   task automatic wait_ack(input int idx);
      int c;
      c = 0;
      while (ack[idx] !== 1'b1 && c < 50) begin
         @(negedge clk);
         c++;
      end
      chk("wait_ack", 64'(c < 50), 64'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

   initial begin
      exp_t e;
      int   c;
      rst        = 1'b0;
      stray_done = 1'b0;
      hang       = 1'b0;
      lat        = 2;
      want       = '{0, 0};
      acked      = '{0, 0};
      opa        = '{32'h0, 32'h0};
      opb        = '{32'h0, 32'h0};
      #1;
      chk("rst_strobes", 64'({ack, rsp_valid, mul_start, busy, rsp_err}), 64'd0);
      chk("rst_rsp", 64'({rsp_p, rsp_flags}), 64'd0);
      chk("rst_mul", 64'({mul_a, mul_b}), 64'd0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      // 1: single request, latency and one-cycle start pulse
      go(0, 32'h40000000, 32'h40400000, 32'h40C00000, 6'h00, 1'b0);
      want[0]++;
      @(negedge clk);
      chk("t1_ack_early", 64'(ack), 64'd0);
      @(negedge clk);
      chk("t1_ack", 64'(ack), 64'd1);
      chk("t1_start", 64'(mul_start), 64'd1);
      @(negedge clk);
      chk("t1_start_pulse", 64'(mul_start), 64'd0);
      chk("t1_busy", 64'(busy), 64'd1);
      drain("t1_drain");

      // 2: both held; last grant was 0 so order is 1,0,1,0
      go(1, 32'h40400000, 32'h40400000, 32'h41100000, 6'h00, 1'b0);
      go(0, 32'h3F800000, 32'h3F800000, 32'h3F800000, 6'h00, 1'b0);
      go(1, 32'h40400000, 32'h40400000, 32'h41100000, 6'h00, 1'b0);
      go(0, 32'h3F800000, 32'h3F800000, 32'h3F800000, 6'h00, 1'b0);
      want[0] += 2;
      want[1] += 2;
      drain("t2_drain");

      // 3: reset during WAIT drops the transaction
      hang = 1'b1;
      e = '{idx: 1, a: 32'h40000000, b: 32'h40400000,
            p: 32'h0, f: 6'h0, err: 1'b0};
      opa[1] = e.a;
      opb[1] = e.b;
      ackq.push_back(e);
      want[1]++;
      wait_ack(1);
      repeat (2) @(negedge clk);
      chk("t3_busy_wait", 64'(busy), 64'd1);
      rst = 1'b0;
      #1;
      chk("t3_rst_strobes", 64'({ack, rsp_valid, mul_start, busy, rsp_err}), 64'd0);
      chk("t3_rst_rsp", 64'({rsp_p, rsp_flags}), 64'd0);
      chk("t3_rst_mul", 64'({mul_a, mul_b}), 64'd0);
      repeat (2) @(negedge clk);
      rst  = 1'b1;
      hang = 1'b0;
      @(negedge clk);
      go(0, 32'h40800000, 32'h3F000000, 32'h40000000, 6'h00, 1'b0);
      go(1, 32'h40400000, 32'h40400000, 32'h41100000, 6'h00, 1'b0);
      want[0]++;
      want[1]++;
      drain("t3_drain");

      // 4: special-value flags routed through
      go(0, 32'h7F800000, 32'h00000000, 32'h7FC00000, 6'h08, 1'b0);
      want[0]++;
      drain("t4_nan_drain");
      go(1, 32'h7F7FFFFF, 32'h40000000, 32'h7F800000, 6'h24, 1'b0);
      want[1]++;
      drain("t4_of_drain");

`ifdef FPM_TIMEOUT_EN
      // 5: watchdog abort after 64 WAIT cycles
      hang = 1'b1;
      go(0, 32'h40000000, 32'h40400000, 32'h0, 6'h00, 1'b1);
      want[0]++;
      wait_ack(0);
      c = 0;
      do begin
         @(negedge clk);
         c++;
      end while (rsp_valid == '0 && c < 200);
      chk("t5_latency", 64'(c), 64'd65);
      drain("t5_drain");
      hang = 1'b0;
      go(1, 32'h3F800000, 32'h3F800000, 32'h3F800000, 6'h00, 1'b0);
      want[1]++;
      drain("t5_after_drain");
`endif

      // 6: stray Done in IDLE and ISSUE is ignored
      @(negedge clk);
      stray_done = 1'b1;
      @(negedge clk);
      stray_done = 1'b0;
      chk("t6_idle_busy", 64'({busy, rsp_valid}), 64'd0);
      @(negedge clk);
      chk("t6_idle_quiet", 64'({busy, rsp_valid}), 64'd0);
      lat = 4;
      go(0, 32'h40000000, 32'h40400000, 32'h40C00000, 6'h00, 1'b0);
      want[0]++;
      wait_ack(0);
      stray_done = 1'b1;
      @(negedge clk);
      stray_done = 1'b0;
      chk("t6_issue_norsp", 64'(rsp_valid), 64'd0);
      chk("t6_issue_busy", 64'(busy), 64'd1);
      drain("t6_drain");

      repeat (3) @(negedge clk);
      chk("end_ackq", 64'(ackq.size()), 64'd0);
      chk("end_rspq", 64'(rspq.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
